// File: rtl/router_input_stage_pkg.sv
// Shared types for the router ingress path: AXI-stream flit/handshake
// structs, the routing-header TID, header field offsets and the ingress FSM
// state encoding.
package router_input_stage_pkg;

  localparam int unsigned AXIS_DATA_WIDTH = 32;
  localparam int unsigned AXIS_ID_WIDTH   = 4;
  localparam int unsigned AXIS_DEST_WIDTH = 4;
  localparam int unsigned AXIS_USER_WIDTH = 4;

  // TID value that marks the first flit of a packet (the routing header).
  localparam logic [AXIS_ID_WIDTH-1:0] ROUTING_HEADER = 4'hF;

  // Destination X sits at the bottom of TDATA; Y follows directly above it,
  // so its offset is HDR_X_LSB plus the mesh X width of the instance.
  localparam int unsigned HDR_X_LSB = 0;

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] tdata;
    logic [AXIS_ID_WIDTH-1:0]   tid;
    logic [AXIS_DEST_WIDTH-1:0] tdest;
    logic [AXIS_USER_WIDTH-1:0] tuser;
    logic                       tlast;
  } axis_data_t;

  typedef struct packed {
    logic       tvalid;
    axis_data_t data;
  } axis_mosi_t;

  typedef struct packed {
    logic tready;
  } axis_miso_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ROUTE   = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

  function automatic logic is_header(input axis_data_t flit);
    return (flit.tid == ROUTING_HEADER);
  endfunction

endpackage

// File: rtl/router_input_stage_fifo.sv
// axis_flit_fifo: small synchronous flit buffer, reusable by the egress stage.
// Ready is a flop derived from the next occupancy, so a full FIFO refuses a
// push even in a cycle where it is popped. DEPTH must be a power of two >= 2
// so the pointers wrap naturally.
module axis_flit_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter type         flit_t = logic [7:0]
) (
  input  logic  clk_i,
  input  logic  rst_n_i,
  input  flit_t push_data_i,
  input  logic  push_valid_i,
  output logic  push_ready_o,
  input  logic  pop_i,
  output flit_t head_o,
  output logic  empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  flit_t          mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ready_q, ready_d;
  logic           push_s;
  logic           pop_s;

  assign push_s       = push_valid_i & ready_q;
  assign pop_s        = pop_i & (cnt_q != {CW{1'b0}});
  assign push_ready_o = ready_q;
  assign empty_o      = (cnt_q == {CW{1'b0}});
  assign head_o       = mem_q[rd_ptr_q];

  // Next pointers, occupancy and the registered ready it implies.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    ready_d = (cnt_d != FULL_CNT);
  end

  // Pointer/occupancy state; reset empties the buffer and drops ready.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/router_input_stage.sv
// router_input_stage: per-port ingress of the NoC router. Buffers flits,
// decodes the routing header into a destination held for the whole packet,
// and discards payload flits that arrive without a header.
// Optional build macro ROUTER_INPUT_STAGE_STATS_EN adds saturating
// packet/drop counters (pkt_cnt_o, drop_cnt_o).
module router_input_stage
  import router_input_stage_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned MAX_ROUTERS_X = 4,
  parameter int unsigned MAX_ROUTERS_Y = 4,
  localparam int unsigned X_W = $clog2(MAX_ROUTERS_X),
  localparam int unsigned Y_W = $clog2(MAX_ROUTERS_Y)
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  axis_mosi_t     in_mosi_i,
  output axis_miso_t     in_miso_o,
  output axis_mosi_t     out_mosi_o,
  input  axis_miso_t     out_miso_i,
  output logic [X_W-1:0] target_x_o,
  output logic [Y_W-1:0] target_y_o,
  output logic           target_vld_o,
  output logic           drop_o
`ifdef ROUTER_INPUT_STAGE_STATS_EN
  ,
  output logic [31:0]    pkt_cnt_o,
  output logic [15:0]    drop_cnt_o
`endif
);

  localparam int unsigned HDR_Y_LSB = HDR_X_LSB + X_W;

  axis_data_t     head_s;
  logic           empty_s;
  logic           fifo_ready_s;
  logic           push_s;
  logic           out_valid_s;
  logic           fwd_s;
  logic           discard_s;
  logic           pop_s;

  state_e         state_q, state_d;
  logic [X_W-1:0] tgt_x_q, tgt_x_d;
  logic [Y_W-1:0] tgt_y_q, tgt_y_d;
  logic           tgt_vld_q;
  logic           drop_q;

  axis_flit_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .flit_t (axis_data_t)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .push_data_i  (in_mosi_i.data),
    .push_valid_i (in_mosi_i.tvalid),
    .push_ready_o (fifo_ready_s),
    .pop_i        (pop_s),
    .head_o       (head_s),
    .empty_o      (empty_s)
  );

  assign push_s      = in_mosi_i.tvalid & fifo_ready_s;
  // The head is only offered once a header has been decoded; in PAYLOAD the
  // FIFO cannot empty under a raised TVALID, so TVALID holds until accepted.
  assign out_valid_s = (state_q != ST_IDLE) & ~empty_s;
  assign fwd_s       = out_valid_s & out_miso_i.tready;
  assign pop_s       = fwd_s | discard_s;

  assign in_miso_o.tready  = fifo_ready_s;
  assign out_mosi_o.tvalid = out_valid_s;
  assign out_mosi_o.data   = head_s;
  assign target_x_o        = tgt_x_q;
  assign target_y_o        = tgt_y_q;
  assign target_vld_o      = tgt_vld_q;
  assign drop_o            = drop_q;

  // Packet FSM: header decode, orphan discard, and end-of-packet detection.
  always_comb begin
    state_d   = state_q;
    tgt_x_d   = tgt_x_q;
    tgt_y_d   = tgt_y_q;
    discard_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          if (is_header(head_s)) begin
            tgt_x_d = head_s.tdata[HDR_X_LSB +: X_W];
            tgt_y_d = head_s.tdata[HDR_Y_LSB +: Y_W];
            state_d = ST_ROUTE;
          end else begin
            discard_s = 1'b1;
          end
        end else if (push_s && is_header(in_mosi_i.data)) begin
          // Header entering an empty FIFO: decode it while it is written so
          // it is offered downstream in the very next cycle.
          tgt_x_d = in_mosi_i.data.tdata[HDR_X_LSB +: X_W];
          tgt_y_d = in_mosi_i.data.tdata[HDR_Y_LSB +: Y_W];
          state_d = ST_ROUTE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ROUTE: begin
        if (fwd_s) begin
          if (head_s.tlast) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else begin
          state_d = ST_ROUTE;
        end
      end
      ST_PAYLOAD: begin
        if (fwd_s && head_s.tlast) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, held destination, target-valid flag and drop pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      tgt_x_q   <= {X_W{1'b0}};
      tgt_y_q   <= {Y_W{1'b0}};
      tgt_vld_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_x_q   <= tgt_x_d;
      tgt_y_q   <= tgt_y_d;
      tgt_vld_q <= (state_d != ST_IDLE);
      drop_q    <= discard_s;
    end
  end

`ifdef ROUTER_INPUT_STAGE_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [15:0] drop_cnt_q;

  assign pkt_cnt_o  = pkt_cnt_q;
  assign drop_cnt_o = drop_cnt_q;

  // Saturating counts of forwarded headers and discarded orphan flits.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pkt_cnt_q  <= 32'd0;
      drop_cnt_q <= 16'd0;
    end else begin
      if (fwd_s && (state_q == ST_ROUTE) && (pkt_cnt_q != 32'hFFFF_FFFF)) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
      if (discard_s && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_router_input_stage.sv
// Self-checking bench for router_input_stage (4x4 mesh, 4-entry FIFO).
module tb_router_input_stage;
  import router_input_stage_pkg::*;

  localparam logic [3:0] HDR_TID = 4'hF;
  localparam int         MESH_X  = 4;
  localparam int         MESH_Y  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  axis_mosi_t in_mosi, out_mosi;
  axis_miso_t in_miso, out_miso;
  logic [1:0] tx, ty;
  logic       tvld, drop;
`ifdef ROUTER_INPUT_STAGE_STATS_EN
  logic [31:0] pkt_cnt;
  logic [15:0] drop_cnt;
`endif

  router_input_stage dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .in_mosi_i    (in_mosi),
    .in_miso_o    (in_miso),
    .out_mosi_o   (out_mosi),
    .out_miso_i   (out_miso),
    .target_x_o   (tx),
    .target_y_o   (ty),
    .target_vld_o (tvld),
    .drop_o       (drop)
`ifdef ROUTER_INPUT_STAGE_STATS_EN
    ,
    .pkt_cnt_o    (pkt_cnt),
    .drop_cnt_o   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  // ---------------- reference model (packet-level) ----------------
  typedef struct {
    axis_data_t d;
    logic [1:0] x;
    logic [1:0] y;
  } exp_t;

  exp_t       exp_q[$];
  axis_data_t src_q[$];
  logic       m_in_pkt = 1'b0;
  logic [1:0] m_x = 2'd0, m_y = 2'd0;
  int         exp_drops = 0, drops_seen = 0;
  int         n_acc = 0, n_out = 0;
  logic       in_hs = 1'b0;

  function automatic void model_accept(input axis_data_t d);
    exp_t e;
    if (!m_in_pkt && d.tid != HDR_TID) begin
      exp_drops++;
    end else begin
      if (!m_in_pkt) begin
        m_x = 2'(d.tdata % MESH_X);
        m_y = 2'((d.tdata / MESH_X) % MESH_Y);
      end
      e.d = d; e.x = m_x; e.y = m_y;
      exp_q.push_back(e);
      m_in_pkt = !d.tlast;
    end
  endfunction

  task automatic drive_cycle(input bit allow, input bit ordy);
    exp_t e;
    @(negedge clk);
    if (in_hs) begin
      in_mosi.tvalid = 1'b0;
      in_hs = 1'b0;
    end
    if (!in_mosi.tvalid && allow && src_q.size() > 0) begin
      in_mosi.data   = src_q.pop_front();
      in_mosi.tvalid = 1'b1;
    end
    out_miso.tready = ordy;
    #1;
    if (drop) drops_seen++;
    if (tvld && exp_q.size() > 0)
      check("tgt_stable", 64'({tx, ty}), 64'({exp_q[0].x, exp_q[0].y}));
    if (out_mosi.tvalid && out_miso.tready) begin
      n_out++;
      check("out_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_flit", 64'(out_mosi.data), 64'(e.d));
        check("out_target", 64'({tvld, tx, ty}), 64'({1'b1, e.x, e.y}));
      end
    end
    if (in_mosi.tvalid && in_miso.tready) begin
      n_acc++;
      in_hs = 1'b1;
      model_accept(in_mosi.data);
    end
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while ((src_q.size() > 0 || in_mosi.tvalid || exp_q.size() > 0) && k < 500) begin
      drive_cycle(1'b1, 1'b1);
      k++;
    end
    repeat (3) drive_cycle(1'b0, 1'b1);
    check({nm, "_drained"}, 64'(exp_q.size() + src_q.size()), 64'd0);
    check({nm, "_drops"}, 64'(drops_seen), 64'(exp_drops));
  endtask

  function automatic axis_data_t mk(input logic [31:0] td, input logic [3:0] tid, input logic tl);
    axis_data_t f;
    f.tdata = td; f.tid = tid; f.tdest = 4'h0; f.tuser = 4'h0; f.tlast = tl;
    return f;
  endfunction

  task automatic gen_random(input int npkt);
    axis_data_t f;
    int len, no;
    for (int p = 0; p < npkt; p++) begin
      if ($urandom_range(0, 7) == 0) begin
        no = $urandom_range(1, 2);
        for (int o = 0; o < no; o++) begin
          f = mk($urandom(), 4'($urandom_range(0, 14)), 1'($urandom_range(0, 1)));
          src_q.push_back(f);
        end
      end
      len = $urandom_range(1, 4);
      f = mk($urandom(), HDR_TID, (len == 1));
      f.tdest = 4'($urandom_range(0, 15));
      f.tuser = 4'($urandom_range(0, 15));
      src_q.push_back(f);
      for (int k = 1; k < len; k++) begin
        f = mk($urandom(), 4'($urandom_range(0, 15)), (k == len - 1));
        f.tuser = 4'($urandom_range(0, 15));
        src_q.push_back(f);
      end
    end
  endtask

  // ---------------- directed per-cycle table ----------------
  typedef struct {
    logic        iv;  logic [31:0] td; logic [3:0] tid; logic tl; logic ordy;
    logic        ov;  logic [31:0] od; logic tv; logic [1:0] x; logic [1:0] y;
    logic        ir;  logic dr;
  } vec_t;

  vec_t tbl[16];

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int base_acc, base_out, cyc;
    // Header x=2,y=1 is TDATA 4'b01_10 (y in [3:2], x in [1:0]).
    tbl[0]  = '{1'b0, 32'h000, 4'h0, 1'b0, 1'b1,  1'b0, 32'h000, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 32'h006, 4'hF, 1'b0, 1'b1,  1'b0, 32'h000, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 32'h111, 4'h1, 1'b0, 1'b1,  1'b1, 32'h006, 1'b1, 2'd2, 2'd1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 32'h222, 4'h1, 1'b0, 1'b1,  1'b1, 32'h111, 1'b1, 2'd2, 2'd1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 32'h333, 4'h1, 1'b1, 1'b1,  1'b1, 32'h222, 1'b1, 2'd2, 2'd1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 32'h000, 4'h0, 1'b0, 1'b1,  1'b1, 32'h333, 1'b1, 2'd2, 2'd1, 1'b1, 1'b0};
    // Two orphan payload flits: discarded, one drop pulse each.
    tbl[6]  = '{1'b1, 32'hAAA, 4'h1, 1'b0, 1'b1,  1'b0, 32'h000, 1'b0, 2'd2, 2'd1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 32'hBBB, 4'h1, 1'b1, 1'b1,  1'b0, 32'h000, 1'b0, 2'd2, 2'd1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 32'h000, 4'h0, 1'b0, 1'b1,  1'b0, 32'h000, 1'b0, 2'd2, 2'd1, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 32'h000, 4'h0, 1'b0, 1'b1,  1'b0, 32'h000, 1'b0, 2'd2, 2'd1, 1'b1, 1'b1};
    // Single-flit packet to 3/3, then header to 0/2 plus one payload.
    tbl[10] = '{1'b1, 32'h00F, 4'hF, 1'b1, 1'b1,  1'b0, 32'h000, 1'b0, 2'd2, 2'd1, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 32'h008, 4'hF, 1'b0, 1'b1,  1'b1, 32'h00F, 1'b1, 2'd3, 2'd3, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 32'h444, 4'h1, 1'b1, 1'b1,  1'b0, 32'h000, 1'b0, 2'd3, 2'd3, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 32'h000, 4'h0, 1'b0, 1'b1,  1'b1, 32'h008, 1'b1, 2'd0, 2'd2, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 32'h000, 4'h0, 1'b0, 1'b1,  1'b1, 32'h444, 1'b1, 2'd0, 2'd2, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 32'h000, 4'h0, 1'b0, 1'b1,  1'b0, 32'h000, 1'b0, 2'd0, 2'd2, 1'b1, 1'b0};

    rst_n = 1'b0;
    in_mosi = '0;
    out_miso.tready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", 64'(out_mosi.tvalid), 64'd0);
    check("reset_in_ready", 64'(in_miso.tready), 64'd0);
    check("reset_target", 64'({tvld, tx, ty}), 64'd0);
    check("reset_drop", 64'(drop), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_mosi.tvalid = tbl[i].iv;
      in_mosi.data   = mk(tbl[i].td, tbl[i].tid, tbl[i].tl);
      out_miso.tready = tbl[i].ordy;
      #1;
      check($sformatf("t%0d_out_valid", i), 64'(out_mosi.tvalid), 64'(tbl[i].ov));
      if (tbl[i].ov)
        check($sformatf("t%0d_out_tdata", i), 64'(out_mosi.data.tdata), 64'(tbl[i].od));
      check($sformatf("t%0d_target_vld", i), 64'(tvld), 64'(tbl[i].tv));
      check($sformatf("t%0d_target_xy", i), 64'({tx, ty}), 64'({tbl[i].x, tbl[i].y}));
      check($sformatf("t%0d_in_ready", i), 64'(in_miso.tready), 64'(tbl[i].ir));
      check($sformatf("t%0d_drop", i), 64'(drop), 64'(tbl[i].dr));
    end
    in_mosi.tvalid = 1'b0;
`ifdef ROUTER_INPUT_STAGE_STATS_EN
    check("stats_pkt_cnt", 64'(pkt_cnt), 64'd3);
    check("stats_drop_cnt", 64'(drop_cnt), 64'd2);
`endif

    // Backpressure: 6-flit packet into a 4-entry FIFO with downstream stalled.
    src_q.push_back(mk(32'h0000_0009, HDR_TID, 1'b0));
    for (int k = 1; k < 6; k++) src_q.push_back(mk(32'h5000 + k, 4'h2, (k == 5)));
    base_acc = n_acc;
    base_out = n_out;
    repeat (12) drive_cycle(1'b1, 1'b0);
    check("bp_accepts", 64'(n_acc - base_acc), 64'd4);
    check("bp_in_ready", 64'(in_miso.tready), 64'd0);
    drain("bp");
    check("bp_out_count", 64'(n_out - base_out), 64'd6);

    // Reset while in PAYLOAD with three flits buffered.
    src_q.push_back(mk(32'h0000_0006, HDR_TID, 1'b0));
    for (int k = 1; k < 5; k++) src_q.push_back(mk(32'h6000 + k, 4'h3, (k == 4)));
    base_acc = n_acc;
    base_out = n_out;
    for (int k = 0; k < 20; k++) begin
      drive_cycle(1'b1, (n_out == base_out));
      if ((n_out - base_out) >= 1 && (n_acc - base_acc - (n_out - base_out)) >= 3) break;
    end
    @(negedge clk);
    check("pre_reset_payload", 64'({tvld, out_mosi.tvalid}), 64'd3);
    rst_n = 1'b0;
    in_mosi.tvalid = 1'b0;
    in_hs = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_out_valid", 64'(out_mosi.tvalid), 64'd0);
    check("midrst_target_vld", 64'(tvld), 64'd0);
    check("midrst_in_ready", 64'(in_miso.tready), 64'd0);
    check("midrst_target", 64'({tx, ty}), 64'd0);
    rst_n = 1'b1;
    exp_q.delete();
    src_q.delete();
    m_in_pkt = 1'b0;
    exp_drops = 0;
    drops_seen = 0;
    // Header x=3,y=1 after reset must be the first flit out: nothing stale.
    src_q.push_back(mk(32'h0000_0007, HDR_TID, 1'b0));
    src_q.push_back(mk(32'h7777, 4'h1, 1'b1));
    drain("post_reset");

    // Random throttling on 1000 packets with interleaved orphans.
    gen_random(1000);
    cyc = 0;
    while ((src_q.size() > 0 || in_mosi.tvalid || exp_q.size() > 0) && cyc < 40000) begin
      drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      cyc++;
    end
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
